// File: rtl/tiny_fir_tap_loader.sv
// Coefficient loader for one tiny_fir instance: host-writable shadow tap table, streamed
// into the FIR over valid/ready after pulsing its enable low, then confirmed via tap_done.
module tiny_fir_tap_loader #(
  parameter int unsigned G_NUM_TAPS     = 16,
  parameter int unsigned G_TAP_WIDTH    = 16,
  parameter int unsigned G_DONE_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(G_NUM_TAPS)-1:0] i_cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]        i_cfg_wr_data,
  input  logic                          i_cfg_wr_valid,
  output logic                          o_cfg_wr_ready,
  input  logic                          i_load_start,
  output logic                          o_load_busy,
  output logic                          o_load_done,
  output logic                          o_load_error,
  output logic                          o_fir_enable,
  output logic [G_TAP_WIDTH-1:0]        o_tap_dout,
  output logic                          o_tap_dout_valid,
  input  logic                          i_tap_dout_ready,
  input  logic                          i_tap_done
);

  localparam int unsigned AW = $clog2(G_NUM_TAPS);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(G_DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StDisable, StArm, StStream, StWaitDone} t_state;

  t_state                 r_state, w_state_nxt;
  logic                   r_dis_cnt, w_dis_cnt_nxt;
  logic [CW-1:0]          r_idx, w_idx_nxt;
  logic [TW-1:0]          r_to_cnt, w_to_cnt_nxt;
  logic                   r_cfg_wr_ready, w_cfg_wr_ready_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_error, w_error_nxt;
  logic                   r_fir_enable, w_fir_enable_nxt;
  logic [G_TAP_WIDTH-1:0] r_tap_dout, w_tap_dout_nxt;
  logic                   r_tap_valid, w_tap_valid_nxt;
  logic [G_TAP_WIDTH-1:0] r_table [G_NUM_TAPS];
  logic                   w_beat;
  logic [AW-1:0]          w_rd_idx;

  // Shadow table is deliberately outside reset so a reset never loses host coefficients.
  always_ff @(posedge clk) begin
    if (i_cfg_wr_valid && r_cfg_wr_ready) begin
      r_table[i_cfg_wr_addr] <= i_cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_dis_cnt      <= 1'b0;
      r_idx          <= '0;
      r_to_cnt       <= '0;
      r_cfg_wr_ready <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_fir_enable   <= 1'b0;
      r_tap_dout     <= '0;
      r_tap_valid    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_dis_cnt      <= w_dis_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_to_cnt       <= w_to_cnt_nxt;
      r_cfg_wr_ready <= w_cfg_wr_ready_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_error        <= w_error_nxt;
      r_fir_enable   <= w_fir_enable_nxt;
      r_tap_dout     <= w_tap_dout_nxt;
      r_tap_valid    <= w_tap_valid_nxt;
    end
  end

  assign w_beat   = r_tap_valid & i_tap_dout_ready;
  assign w_rd_idx = r_idx[AW-1:0] + AW'(1);

  always_comb begin
    w_state_nxt        = r_state;
    w_dis_cnt_nxt      = r_dis_cnt;
    w_idx_nxt          = r_idx;
    w_to_cnt_nxt       = r_to_cnt;
    w_cfg_wr_ready_nxt = r_cfg_wr_ready;
    w_busy_nxt         = r_busy;
    w_done_nxt         = 1'b0;
    w_error_nxt        = r_error;
    w_fir_enable_nxt   = r_fir_enable;
    w_tap_dout_nxt     = r_tap_dout;
    w_tap_valid_nxt    = r_tap_valid;
    unique case (r_state)
      StIdle: begin
        if (i_load_start) begin
          w_state_nxt        = StDisable;
          w_dis_cnt_nxt      = 1'b0;
          w_busy_nxt         = 1'b1;
          w_cfg_wr_ready_nxt = 1'b0;
          w_error_nxt        = 1'b0;
          w_fir_enable_nxt   = 1'b0;
        end
      end
      StDisable: begin
        w_dis_cnt_nxt = 1'b1;
        if (r_dis_cnt) begin
          w_state_nxt      = StArm;
          w_fir_enable_nxt = 1'b1;
        end
      end
      StArm: begin
        w_state_nxt     = StStream;
        w_idx_nxt       = '0;
        w_tap_dout_nxt  = r_table[0];
        w_tap_valid_nxt = 1'b1;
      end
      StStream: begin
        if (w_beat) begin
          if (r_idx == CW'(G_NUM_TAPS - 1)) begin
            w_state_nxt     = StWaitDone;
            w_tap_valid_nxt = 1'b0;
            w_to_cnt_nxt    = '0;
          end else begin
            w_idx_nxt      = r_idx + CW'(1);
            w_tap_dout_nxt = r_table[w_rd_idx];
          end
        end
      end
      StWaitDone: begin
        if (i_tap_done) begin
          w_state_nxt        = StIdle;
          w_done_nxt         = 1'b1;
          w_busy_nxt         = 1'b0;
          w_cfg_wr_ready_nxt = 1'b1;
        end else if (r_to_cnt == TW'(G_DONE_TIMEOUT - 1)) begin
          w_state_nxt        = StIdle;
          w_error_nxt        = 1'b1;
          w_busy_nxt         = 1'b0;
          w_cfg_wr_ready_nxt = 1'b1;
          w_fir_enable_nxt   = 1'b0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_cfg_wr_ready   = r_cfg_wr_ready;
  assign o_load_busy      = r_busy;
  assign o_load_done      = r_done;
  assign o_load_error     = r_error;
  assign o_fir_enable     = r_fir_enable;
  assign o_tap_dout       = r_tap_dout;
  assign o_tap_dout_valid = r_tap_valid;

endmodule

// File: tb/tb_tiny_fir_tap_loader.sv
// Bench for tiny_fir_tap_loader: directed loads against a table/queue model and a tiny_fir stub.
module tb_tiny_fir_tap_loader;
  localparam int unsigned N  = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   cfg_wr_addr = '0;
  logic [W-1:0] cfg_wr_data = '0;
  logic         cfg_wr_valid = 1'b0;
  logic         cfg_wr_ready;
  logic         load_start = 1'b0;
  logic         load_busy, load_done, load_error, fir_enable;
  logic [W-1:0] tap_dout;
  logic         tap_dout_valid;
  logic         tap_dout_ready = 1'b1;
  logic         tap_done;

  tiny_fir_tap_loader #(
    .G_NUM_TAPS    (N),
    .G_TAP_WIDTH   (W),
    .G_DONE_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_cfg_wr_addr   (cfg_wr_addr),
    .i_cfg_wr_data   (cfg_wr_data),
    .i_cfg_wr_valid  (cfg_wr_valid),
    .o_cfg_wr_ready  (cfg_wr_ready),
    .i_load_start    (load_start),
    .o_load_busy     (load_busy),
    .o_load_done     (load_done),
    .o_load_error    (load_error),
    .o_fir_enable    (fir_enable),
    .o_tap_dout      (tap_dout),
    .o_tap_dout_valid(tap_dout_valid),
    .i_tap_dout_ready(tap_dout_ready),
    .i_tap_done      (tap_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [W-1:0] model_tab [N];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] beat_vals [N];
  int ld_beats = 0, done_cnt = 0;
  int start_edge = 0, first_beat_edge = 0, last_beat_edge = 0, done_edge = 0, err_edge = 0;
  logic [W-1:0] last_beat_val = '0, prev_dout = '0;
  logic prev_stall = 1'b0, prev_err = 1'b0;
  logic rdy_rand = 1'b0;
  int done_mode = 0;  // 0: FIR stub, 1: tap_done stuck low, 2: tap_done stuck high

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) tap_dout_ready <= rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;

  // tiny_fir stub: enable low clears it; done after N accepted taps, held until enable drops
  int   fir_cnt = 0;
  logic fir_done = 1'b0;
  always @(posedge clk) begin
    if (reset || !fir_enable) begin
      fir_cnt  <= 0;
      fir_done <= 1'b0;
    end else if (tap_dout_valid && tap_dout_ready && fir_cnt < N) begin
      fir_cnt  <= fir_cnt + 1;
      fir_done <= (fir_cnt == N - 1);
    end
  end
  assign tap_done = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : fir_done;

  // Compare process: beats against the expected queue, stall stability, done/error timing.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", tap_dout_valid, 1);
        chk("stall_data_hold", tap_dout, prev_dout);
      end
      if (tap_dout_valid) chk("enable_while_valid", fir_enable, 1);
      if (tap_dout_valid && tap_dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat_value", tap_dout, exp_q.pop_front());
        if (ld_beats == 0) first_beat_edge = cyc + 1;
        last_beat_edge = cyc + 1;
        last_beat_val  = tap_dout;
        if (ld_beats < N) beat_vals[ld_beats] = tap_dout;
        ld_beats++;
      end
      if (load_done) begin
        done_cnt++;
        done_edge = cyc;
        chk("all_beats_before_done", exp_q.size(), 0);
      end
      if (load_error && !prev_err) err_edge = cyc;
      prev_err   = load_error;
      prev_stall = tap_dout_valid && !tap_dout_ready;
      prev_dout  = tap_dout;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [W-1:0] d, input logic exp_acc);
    cfg_wr_addr  = 4'(a);
    cfg_wr_data  = d;
    cfg_wr_valid = 1'b1;
    chk("cfg_wr_ready", cfg_wr_ready, 32'(exp_acc));
    if (exp_acc) model_tab[a] = d;
    step();
    cfg_wr_valid = 1'b0;
  endtask

  // Caller guarantees the loader is idle, so the table snapshot is what must stream out.
  task automatic start_load();
    load_start = 1'b1;
    start_edge = cyc + 1;
    ld_beats   = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(model_tab[i]);
    step();
    load_start   = 1'b0;
    cfg_wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (load_busy && n < budget) begin
      step();
      n++;
    end
    if (load_busy) chk(name, 32'(load_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    // 1: reset values
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cfg_wr_ready", cfg_wr_ready, 1);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_fir_enable", fir_enable, 0);
    chk("rst_tap_dout", tap_dout, 0);
    chk("rst_valid", tap_dout_valid, 0);

    // 2: full load, ready high; table[15] written in the start cycle
    step();
    for (int k = 0; k < 15; k++) cfg_write(k, W'(k * 16'h0101), 1'b1);
    cfg_wr_addr  = 4'd15;
    cfg_wr_data  = 16'h0F0F;
    cfg_wr_valid = 1'b1;
    model_tab[15] = 16'h0F0F;
    start_load();
    @(negedge clk);
    chk("t2_busy", load_busy, 1);
    chk("t2_wr_ready_busy", cfg_wr_ready, 0);
    chk("t2_en_dis1", fir_enable, 0);
    chk("t2_valid_dis1", tap_dout_valid, 0);
    step();
    @(negedge clk);
    chk("t2_en_dis2", fir_enable, 0);
    step();
    @(negedge clk);
    chk("t2_en_arm", fir_enable, 1);
    chk("t2_valid_arm", tap_dout_valid, 0);
    step();
    @(negedge clk);
    chk("t2_valid_first", tap_dout_valid, 1);
    chk("t2_first_tap", tap_dout, 16'h0000);
    wait_idle(100, "t2_done_timeout");
    repeat (3) step();
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_beats", ld_beats, 16);
    chk("t2_first_latency", first_beat_edge - start_edge, 4);
    chk("t2_contiguous", last_beat_edge - first_beat_edge, 15);
    chk("t2_last_tap", last_beat_val, 16'h0F0F);
    chk("t2_error", load_error, 0);
    chk("t2_en_after", fir_enable, 1);
    chk("t2_wr_ready_after", cfg_wr_ready, 1);

    // 3: random backpressure
    rdy_rand = 1'b1;
    start_load();
    wait_idle(300, "t3_done_timeout");
    repeat (3) step();
    rdy_rand = 1'b0;
    chk("t3_done_cnt", done_cnt, 2);
    chk("t3_beats", ld_beats, 16);
    chk("t3_last_tap", last_beat_val, 16'h0F0F);
    chk("t3_error", load_error, 0);

    // stale tap_done high must not finish the load before the last beat
    done_mode = 2;
    start_load();
    wait_idle(100, "stale_done_timeout");
    repeat (2) step();
    done_mode = 0;
    chk("stale_done_cnt", done_cnt, 3);
    chk("stale_beats", ld_beats, 16);
    chk("stale_done_latency", done_edge - last_beat_edge, 1);

    // 4: tap_done never arrives
    done_mode = 1;
    start_load();
    wait_idle(400, "t4_error_timeout");
    repeat (2) step();
    chk("t4_error", load_error, 1);
    chk("t4_error_latency", err_edge - last_beat_edge, TO);
    chk("t4_en_off", fir_enable, 0);
    chk("t4_no_done", done_cnt, 3);
    chk("t4_wr_ready", cfg_wr_ready, 1);
    done_mode = 0;
    start_load();
    @(negedge clk);
    chk("t4_error_cleared", load_error, 0);
    wait_idle(100, "t4_reload_timeout");
    repeat (2) step();
    chk("t4_reload_done", done_cnt, 4);

    // 5: reset right after beat 5, then reload from index 0
    start_load();
    base = 0;
    while (ld_beats < 6 && base < 50) begin
      step();
      base++;
    end
    chk("t5_reached_beat5", ld_beats, 6);
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", tap_dout_valid, 0);
    chk("t5_en", fir_enable, 0);
    chk("t5_busy", load_busy, 0);
    chk("t5_wr_ready", cfg_wr_ready, 1);
    step();
    start_load();
    wait_idle(100, "t5_reload_timeout");
    repeat (2) step();
    chk("t5_done_cnt", done_cnt, 5);
    chk("t5_beats", ld_beats, 16);
    chk("t5_first_tap", beat_vals[0], 16'h0000);
    chk("t5_tap5", beat_vals[5], 16'h0505);

    // 6: write and second start while busy are both ignored
    start_load();
    cfg_write(3, 16'hDEAD, 1'b0);
    repeat (3) step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    wait_idle(100, "t6_done_timeout");
    repeat (10) step();
    chk("t6_single_done", done_cnt, 6);
    chk("t6_idle", load_busy, 0);
    start_load();
    wait_idle(100, "t6_reload_timeout");
    repeat (2) step();
    chk("t6_reload_done", done_cnt, 7);
    chk("t6_tap3_unchanged", beat_vals[3], 16'h0303);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
